uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 72 +++++++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity-type constants and the
// parity helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int unsigned UART_MAX_WIDTH = 32;

  // Expected parity bit for a data word: XOR of the bits for even parity,
  // inverted for odd parity. Zero-extension leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [UART_MAX_WIDTH-1:0] data,
                                      input logic                      typ);
    return (^data) ^ (typ == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// UART receive front end: 2-flop synchroniser, per-bit edge counter and
// 3-sample mid-bit majority vote.
module uart_rx_sampler #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  input  logic start,     // start-bit detect cycle: counts as edge 0
  input  logic active,    // a frame is in progress
  output logic rx_s,
  output logic bit_val,   // majority of the three mid-bit samples
  output logic vote_ok,   // bit_val is final from this cycle on
  output logic bit_done   // last cycle of the current bit period
);

  localparam int unsigned   EW   = $clog2(PRESCALE);
  localparam logic [EW-1:0] S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);

  logic          sync1;
  logic [EW-1:0] edge_cnt;
  logic [2:0]    samp;
  logic          third;

  // Two-stage synchroniser, idles high like the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // Edge counter: restarts at 1 after the detect cycle, wraps every bit, parks at 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (start) begin
      edge_cnt <= EW'(1);
    end else if (!active || edge_cnt == LAST) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + EW'(1);
    end
  end

  // Capture the three mid-bit samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
    end else begin
      if (edge_cnt == S0) samp[0] <= rx_s;
      if (edge_cnt == S1) samp[1] <= rx_s;
      if (edge_cnt == S2) samp[2] <= rx_s;
    end
  end

  // Majority vote; the third sample is taken live in its own cycle so the
  // vote is already final there (needed when PRESCALE = 4).
  always_comb begin
    third    = (edge_cnt == S2) ? rx_s : samp[2];
    bit_val  = (samp[0] & samp[1]) | (samp[0] & third) | (samp[1] & third);
    vote_ok  = (edge_cnt == S2);
    bit_done = (edge_cnt == LAST);
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frames start/data/optional parity/stop from the sampled
// line and reports a good word or error flags as one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned P_Data_Width = 8,
  parameter int unsigned PRESCALE     = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    RX_IN,
  input  logic                    Parity_EN,
  input  logic                    Parity_TYP,
  output logic [P_Data_Width-1:0] P_Data,
  output logic                    Data_Valid,
  output logic                    Parity_Error,
  output logic                    Stop_Error
);

  if ((PRESCALE % 2) != 0 || PRESCALE < 4) begin : g_prescale_chk
    $error("uart_rx: PRESCALE must be even and >= 4");
  end
  if (P_Data_Width < 1 || P_Data_Width > UART_MAX_WIDTH) begin : g_width_chk
    $error("uart_rx: P_Data_Width out of range");
  end

  localparam int unsigned    BCW      = (P_Data_Width > 1) ? $clog2(P_Data_Width) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(P_Data_Width - 1);

  uart_state_e               state;
  logic [P_Data_Width-1:0]   shreg;
  logic [P_Data_Width:0]     shift_nxt;
  logic [BCW-1:0]            bit_cnt;
  logic                      par_en_l;
  logic                      par_typ_l;
  logic                      par_err;
  logic [UART_MAX_WIDTH-1:0] par_vec;
  logic                      par_exp;

  logic rx_s;
  logic bit_val;
  logic vote_ok;
  logic bit_done;
  logic start;
  logic active;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk     (Clk),
    .rst_n   (Reset),
    .rx_in   (RX_IN),
    .start   (start),
    .active  (active),
    .rx_s    (rx_s),
    .bit_val (bit_val),
    .vote_ok (vote_ok),
    .bit_done(bit_done)
  );

  // Start detect, shift-in value and expected parity of the received word.
  always_comb begin
    start     = (state == IDLE) && !rx_s;
    active    = (state != IDLE);
    shift_nxt = {bit_val, shreg} >> 1;
    par_vec   = '0;
    par_vec[P_Data_Width-1:0] = shreg;
    par_exp   = parity_bit(par_vec, par_typ_l);
  end

  // Frame FSM with shift register, parity check and registered result pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      par_en_l     <= 1'b0;
      par_typ_l    <= 1'b0;
      par_err      <= 1'b0;
      P_Data       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            par_en_l  <= Parity_EN;
            par_typ_l <= Parity_TYP;
            par_err   <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (vote_ok && bit_val) begin
            state <= IDLE;
          end else if (bit_done) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shreg <= shift_nxt[P_Data_Width-1:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_l ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            par_err <= (bit_val != par_exp);
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            state        <= IDLE;
            Parity_Error <= par_err;
            Stop_Error   <= !bit_val;
            if (!par_err && bit_val) begin
              P_Data     <= shreg;
              Data_Valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames, randomized
// frames against a frame-level model, and hand-written glitch/reset sequences.
module tb_uart_rx;

  localparam int unsigned DW       = 8;
  localparam int unsigned PRESCALE = 8;

  logic          Clk;
  logic          Reset;
  logic          RX_IN;
  logic          Parity_EN;
  logic          Parity_TYP;
  logic [DW-1:0] P_Data;
  logic          Data_Valid;
  logic          Parity_Error;
  logic          Stop_Error;

  uart_rx #(
    .P_Data_Width(DW),
    .PRESCALE    (PRESCALE)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .RX_IN       (RX_IN),
    .Parity_EN   (Parity_EN),
    .Parity_TYP  (Parity_TYP),
    .P_Data      (P_Data),
    .Data_Valid  (Data_Valid),
    .Parity_Error(Parity_Error),
    .Stop_Error  (Stop_Error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [DW-1:0] data;
    bit            en;
    bit            typ;
    bit            pb;
    bit            stop;
    bit            tog;
    int unsigned   gap;
    bit            dv;
    bit            pe;
    bit            se;
    logic [DW-1:0] pd;
  } vec_t;

  typedef struct {
    int unsigned   cyc;
    bit            dv;
    bit            pe;
    bit            se;
    logic [DW-1:0] pd;
  } exp_t;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] hold_pdata = '0;
  logic [DW-1:0] model_pdata = '0;
  vec_t          tbl[$];

  always @(posedge Clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every pulse must match the next expected frame outcome.
  always @(negedge Clk) begin
    if (!Reset) begin
      hold_pdata = '0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        check("missing_pulse_cycle", cyc, mon_e.cyc);
      end
      if (Data_Valid || Parity_Error || Stop_Error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, Data_Valid, Parity_Error, Stop_Error}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_cycle", cyc, mon_e.cyc);
          check("data_valid", {31'd0, Data_Valid}, {31'd0, mon_e.dv});
          check("parity_error", {31'd0, Parity_Error}, {31'd0, mon_e.pe});
          check("stop_error", {31'd0, Stop_Error}, {31'd0, mon_e.se});
          check("p_data", {24'd0, P_Data}, {24'd0, mon_e.pd});
          hold_pdata = mon_e.pd;
        end
      end else begin
        check("p_data_hold", {24'd0, P_Data}, {24'd0, hold_pdata});
      end
    end
  end

  function automatic vec_t mk(input logic [DW-1:0] data, input bit en, input bit typ,
                              input bit pb, input bit stop, input bit tog,
                              input int unsigned gap, input bit dv, input bit pe,
                              input bit se, input logic [DW-1:0] pd);
    vec_t v;
    v.data = data; v.en = en; v.typ = typ; v.pb = pb; v.stop = stop; v.tog = tog;
    v.gap = gap; v.dv = dv; v.pe = pe; v.se = se; v.pd = pd;
    return v;
  endfunction

  // Frame-level reference: outcome follows from parity/stop rules directly.
  function automatic vec_t model_frame(input logic [DW-1:0] data, input bit en, input bit typ,
                                       input bit pb, input bit stop, input bit tog,
                                       input int unsigned gap);
    bit pe, se, dv;
    pe = en && (pb != ((^data) ^ typ));
    se = !stop;
    dv = !pe && !se;
    return mk(data, en, typ, pb, stop, tog, gap, dv, pe, se, dv ? data : model_pdata);
  endfunction

  task automatic drive_bit(input logic b);
    @(posedge Clk);
    #1;
    RX_IN = b;
    repeat (PRESCALE - 1) @(posedge Clk);
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    @(posedge Clk);
    #1;
    Parity_EN  = v.en;
    Parity_TYP = v.typ;
    RX_IN      = 1'b0;
    e.cyc = cyc + 2 + (DW + 2 + int'(v.en)) * PRESCALE;
    e.dv  = v.dv;
    e.pe  = v.pe;
    e.se  = v.se;
    e.pd  = v.pd;
    exp_q.push_back(e);
    repeat (PRESCALE - 1) @(posedge Clk);
    for (int i = 0; i < DW; i++) begin
      if (v.tog && i == 3) Parity_TYP = !Parity_TYP;
      drive_bit(v.data[i]);
    end
    if (v.en) drive_bit(v.pb);
    drive_bit(v.stop);
    repeat (v.gap) begin
      @(posedge Clk);
      #1;
      RX_IN = 1'b1;
    end
    model_pdata = v.pd;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      RX_IN = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    Reset      = 1'b1;
    RX_IN      = 1'b1;
    Parity_EN  = 1'b0;
    Parity_TYP = 1'b0;
    #2 Reset = 1'b0;

    //          data   en typ pb st tog gap dv pe se pd
    tbl.push_back(mk(8'hA5, 0, 0, 0, 1, 0, 3, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(8'h3C, 1, 0, 0, 1, 0, 3, 1, 0, 0, 8'h3C));
    tbl.push_back(mk(8'h3C, 1, 0, 1, 1, 0, 3, 0, 1, 0, 8'h3C));
    tbl.push_back(mk(8'hFF, 1, 1, 1, 1, 1, 3, 1, 0, 0, 8'hFF));
    tbl.push_back(mk(8'h12, 0, 0, 0, 0, 0, 5, 0, 0, 1, 8'hFF));
    tbl.push_back(mk(8'h55, 0, 0, 0, 1, 0, 3, 1, 0, 0, 8'h55));
    tbl.push_back(mk(8'h01, 1, 0, 0, 0, 0, 2, 0, 1, 1, 8'h55));
    tbl.push_back(mk(8'h00, 1, 1, 1, 1, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(8'hE7, 0, 1, 0, 1, 1, 4, 1, 0, 0, 8'hE7));

    repeat (3) @(negedge Clk);
    check("reset_p_data", {24'd0, P_Data}, 32'd0);
    check("reset_flags", {29'd0, Data_Valid, Parity_Error, Stop_Error}, 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    idle(10);

    foreach (tbl[i]) send_frame(tbl[i]);
    idle(10);

    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] d;
      bit en, typ, pb, stop;
      d    = DW'($urandom);
      en   = 1'($urandom);
      typ  = 1'($urandom);
      pb   = ((^d) ^ typ) ^ ($urandom_range(0, 4) == 0);
      stop = ($urandom_range(0, 5) != 0);
      v = model_frame(d, en, typ, pb, stop, 1'($urandom),
                      stop ? $urandom_range(0, 2) : $urandom_range(1, 3));
      send_frame(v);
    end
    idle(10);

    // Glitch of two clocks, then a frame starting just as the FSM is back in IDLE.
    @(posedge Clk);
    #1 RX_IN = 1'b0;
    repeat (2) @(posedge Clk);
    #1 RX_IN = 1'b1;
    repeat (3) @(posedge Clk);
    send_frame(model_frame(8'h81, 0, 0, 0, 1, 0, 5));
    idle(10);

    // Reset during data bit 4 of a frame, after a good word is held.
    send_frame(model_frame(8'h5A, 0, 0, 0, 1, 0, 5));
    idle(10);
    @(posedge Clk);
    #1;
    Parity_EN = 1'b0;
    RX_IN     = 1'b0;
    repeat (PRESCALE - 1) @(posedge Clk);
    for (int i = 0; i < 4; i++) drive_bit(1'(i % 2));
    @(posedge Clk);
    #1 RX_IN = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    RX_IN = 1'b1;
    #1;
    check("mid_reset_p_data", {24'd0, P_Data}, 32'd0);
    check("mid_reset_flags", {29'd0, Data_Valid, Parity_Error, Stop_Error}, 32'd0);
    model_pdata = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    idle(12);
    send_frame(model_frame(8'hC3, 0, 0, 0, 1, 0, 5));

    idle(120);
    check("pending_pulses", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
